// File: rtl/generic_fifo_dc.sv
// generic_fifo_dc: single-clock FIFO, 2**aw x dw, registered read port.
// Exact full/empty, near-full/near-empty and a 2-bit coarse fill level.
//
// Ports:
//   clk      rising-edge clock
//   rst      async reset, active low
//   clr      sync clear, active high, beats we/re
//   din/we   write data and strobe (ignored while full)
//   dout/re  registered read data and strobe (ignored while empty)
//   full     count == DEPTH
//   empty    count == 0
//   full_n   count >= DEPTH-n
//   empty_n  count <= n
//   level    full ? 3 : count[aw-1:aw-2]
// Option GENERIC_FIFO_DC_ERR_EN adds sticky ovf/udf error flags.
module generic_fifo_dc #(
  parameter int dw = 8,
  parameter int aw = 8,
  parameter int n  = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [dw-1:0] din,
  input  logic          we,
  output logic [dw-1:0] dout,
  input  logic          re,
  output logic          full,
  output logic          empty,
  output logic          full_n,
  output logic          empty_n,
`ifdef GENERIC_FIFO_DC_ERR_EN
  output logic          ovf,
  output logic          udf,
`endif
  output logic [1:0]    level
);

  localparam int DEPTH = 1 << aw;

  localparam logic [aw:0]   CNT_FULL = (aw+1)'(DEPTH);
  localparam logic [aw:0]   CNT_NF   = (aw+1)'(DEPTH - n);
  localparam logic [aw:0]   CNT_NE   = (aw+1)'(n);
  localparam logic [aw:0]   CNT_ONE  = (aw+1)'(1);
  localparam logic [aw-1:0] PTR_ONE  = aw'(1);

  logic [aw-1:0] wp_q, wp_d;
  logic [aw-1:0] rp_q, rp_d;
  logic [aw:0]   cnt_q, cnt_d;
  logic [dw-1:0] dout_q, dout_d;
  logic [dw-1:0] mem_q [DEPTH];

  logic wr_ok;
  logic rd_ok;

  assign full    = (cnt_q == CNT_FULL);
  assign empty   = (cnt_q == '0);
  assign full_n  = (cnt_q >= CNT_NF);
  assign empty_n = (cnt_q <= CNT_NE);
  assign level   = full ? 2'b11 : cnt_q[aw-1:aw-2];
  assign dout    = dout_q;

  // clr suppresses both accesses so memory and dout stay put
  assign wr_ok = we & ~full & ~clr;
  assign rd_ok = re & ~empty & ~clr;

  always_comb begin
    wp_d   = wp_q;
    rp_d   = rp_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (clr) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (wr_ok) wp_d = wp_q + PTR_ONE;
      if (rd_ok) begin
        rp_d   = rp_q + PTR_ONE;
        dout_d = mem_q[rp_q];
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  // storage has no reset so it can map onto RAM
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wp_q] <= din;
  end

`ifdef GENERIC_FIFO_DC_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q | (we & full);
    udf_d = udf_q | (re & empty);
    if (clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

endmodule

// File: tb/tb_generic_fifo_dc.sv
// tb_generic_fifo_dc: randomized bench for generic_fifo_dc.
// Queue-based reference model, all checks through chk.
module tb_generic_fifo_dc;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int NT    = 9;
  localparam int DEPTH = 256;

  logic          clk;
  logic          rst;
  logic          clr;
  logic [DW-1:0] din;
  logic          we;
  logic [DW-1:0] dout;
  logic          re;
  logic          full;
  logic          empty;
  logic          full_n;
  logic          empty_n;
  logic [1:0]    level;
`ifdef GENERIC_FIFO_DC_ERR_EN
  logic          ovf;
  logic          udf;
`endif

  generic_fifo_dc #(.dw(DW), .aw(AW), .n(NT)) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .din     (din),
    .we      (we),
    .dout    (dout),
    .re      (re),
    .full    (full),
    .empty   (empty),
    .full_n  (full_n),
    .empty_n (empty_n),
`ifdef GENERIC_FIFO_DC_ERR_EN
    .ovf     (ovf),
    .udf     (udf),
`endif
    .level   (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] dout_m;
  bit            ovf_m;
  bit            udf_m;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int c;
    int lv;
    c  = q.size();
    lv = (c == DEPTH) ? 3 : (c * 4) / DEPTH;
    chk({tag, ":dout"},  32'(dout), 32'(dout_m));
    chk({tag, ":x"},     32'($isunknown(dout)), 32'd0);
    chk({tag, ":empty"}, 32'(empty), 32'(c == 0));
    chk({tag, ":full"},  32'(full), 32'(c == DEPTH));
    chk({tag, ":ne"},    32'(empty_n), 32'(c <= NT));
    chk({tag, ":nf"},    32'(full_n), 32'(c >= DEPTH - NT));
    chk({tag, ":lvl"},   32'(level), 32'(lv));
`ifdef GENERIC_FIFO_DC_ERR_EN
    chk({tag, ":ovf"},   32'(ovf), 32'(ovf_m));
    chk({tag, ":udf"},   32'(udf), 32'(udf_m));
`endif
  endtask

  // one clock: drive, clock, update model, compare
  task automatic step(input string tag, input bit w, input bit r,
                      input logic [DW-1:0] d, input bit c);
    int cnt;
    we  = w;
    re  = r;
    din = d;
    clr = c;
    @(posedge clk);
    #1;
    cnt = q.size();
    if (c) begin
      q.delete();
      ovf_m = 1'b0;
      udf_m = 1'b0;
    end else begin
      if (w && cnt == DEPTH) ovf_m = 1'b1;
      if (r && cnt == 0) udf_m = 1'b1;
      if (r && cnt > 0) dout_m = q.pop_front();
      if (w && cnt < DEPTH) q.push_back(d);
    end
    we  = 1'b0;
    re  = 1'b0;
    clr = 1'b0;
    check_all(tag);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step("idle", 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wr(input logic [DW-1:0] d);
    step("wr", 1'b1, 1'b0, d, 1'b0);
  endtask

  task automatic rd();
    step("rd", 1'b0, 1'b1, 8'h00, 1'b0);
  endtask

  task automatic model_reset();
    q.delete();
    dout_m = '0;
    ovf_m  = 1'b0;
    udf_m  = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] cap;
    int            c0;
    rst = 1'b0;
    clr = 1'b0;
    we  = 1'b0;
    re  = 1'b0;
    din = '0;
    model_reset();

    repeat (10) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b1;
    idle(2);

    // single write then read
    d = 8'($urandom);
    wr(d);
    chk("one:cnt1", 32'(q.size()), 32'd1);
    rd();
    chk("one:data", 32'(dout), 32'(d));
    chk("one:empty", 32'(empty), 32'd1);

    // bursts with random gaps
    for (int rep = 0; rep < 5; rep++) begin
      for (int b = 1; b <= 4; b++) begin
        for (int i = 0; i < b; i++) begin
          wr(8'($urandom));
          idle($urandom_range(0, 24));
        end
        idle($urandom_range(2, 5));
        for (int i = 0; i < b; i++) begin
          rd();
          idle($urandom_range(0, 24));
        end
      end
    end

    // fill to full, overflow attempts, drain across wrap
    for (int i = 0; i < DEPTH; i++) wr(8'($urandom));
    chk("fill:full", 32'(full), 32'd1);
    chk("fill:lvl", 32'(level), 32'd3);
    wr(8'h3C);
    chk("fill:drop", 32'(q.size()), 32'd256);
    step("fullrw", 1'b1, 1'b1, 8'h5A, 1'b0);
    chk("fullrw:cnt", 32'(full), 32'd0);
    wr(8'h77);
    while (q.size() > 0) rd();
    rd();
    chk("drain:empty", 32'(empty), 32'd1);

    // clr also drops sticky error flags
    step("clr0", 1'b0, 1'b0, 8'h00, 1'b1);

    // simultaneous read and write at count 5
    for (int i = 0; i < 5; i++) wr(8'($urandom));
    step("rw5", 1'b1, 1'b1, 8'hC3, 1'b0);
    chk("rw5:cnt", 32'(q.size()), 32'd5);
    while (q.size() > 0) rd();

    // clear at count 100
    for (int i = 0; i < 100; i++) wr(8'($urandom));
    cap = dout_m;
    step("clr", 1'b1, 1'b1, 8'hEE, 1'b1);
    chk("clr:empty", 32'(empty), 32'd1);
    chk("clr:lvl", 32'(level), 32'd0);
    chk("clr:dout", 32'(dout), 32'(cap));
    wr(8'hA5);
    rd();
    chk("clr:a5", 32'(dout), 32'hA5);

    // random soak
    for (int i = 0; i < 3000; i++) begin
      step("soak", bit'($urandom_range(0, 99) < 55),
           bit'($urandom_range(0, 99) < 45),
           8'($urandom), bit'($urandom_range(0, 999) == 0));
    end

    // asynchronous reset mid-cycle, checked before any edge
    c0 = q.size();
    if (c0 == 0) wr(8'h11);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
